// File: rtl/ibex_csr_wr_sequencer_if.sv
// Requester and CSR-bank signals of the write-and-verify sequencer.
// The slave modport belongs to the sequencer. The master modport belongs to its environment.
interface ibex_csr_wr_sequencer_if #(
  parameter int NumReq = 3,
  parameter int NumCsr = 8,
  parameter int AddrW  = 4,
  parameter int Width  = 32
);
  logic [NumReq-1:0]             req_valid_i;
  logic [NumReq-1:0][AddrW-1:0]  req_addr_i;
  logic [NumReq-1:0][Width-1:0]  req_wdata_i;
  logic [NumReq-1:0]             req_gnt_o;
  logic [NumReq-1:0]             req_done_o;
  logic [1:0]                    req_status_o;
  logic [NumCsr-1:0]             csr_lock_i;
  logic [NumCsr-1:0]             csr_wr_en_o;
  logic [Width-1:0]              csr_wr_data_o;
  logic [NumCsr-1:0][Width-1:0]  csr_rd_data_i;
  logic [NumCsr-1:0]             csr_rd_error_i;
  logic                          busy_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_wdata_i, csr_lock_i, csr_rd_data_i, csr_rd_error_i,
    output req_gnt_o, req_done_o, req_status_o, csr_wr_en_o, csr_wr_data_o, busy_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, csr_lock_i, csr_rd_data_i, csr_rd_error_i,
    input  req_gnt_o, req_done_o, req_status_o, csr_wr_en_o, csr_wr_data_o, busy_o
  );
endinterface

// File: rtl/ibex_csr_wr_sequencer.sv
// Round-robin write-and-verify sequencer for a bank of CSR primitives.
// Each request runs write, settle, and masked read-back check, then reports a status.
module ibex_csr_wr_sequencer #(
  parameter int              NumReq     = 3,
  parameter int              NumCsr     = 8,
  parameter int              AddrW      = 4,
  parameter int              Width      = 32,
  parameter logic [Width-1:0] VerifyMask = 32'hFFFF_FFDF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  ibex_csr_wr_sequencer_if.slave  bus
);
  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, SETTLE, CHECK} state_e;

  localparam logic [1:0] StOk       = 2'd0;
  localparam logic [1:0] StLocked   = 2'd1;
  localparam logic [1:0] StMismatch = 2'd2;
  localparam logic [1:0] StShadow   = 2'd3;

  state_e            state_q;
  logic [IdxW-1:0]   idx_q, last_gnt_q;
  logic [AddrW-1:0]  addr_q;
  logic [Width-1:0]  wdata_q;
  logic [1:0]        status_q;
  logic [NumCsr-1:0] wr_en_q;
  logic [NumReq-1:0] done_q;
  logic              busy_q;

  // Round-robin pick: lowest valid index above last_gnt, else lowest valid index overall.
  logic              lo_found, hi_found, gnt_any;
  logic [IdxW-1:0]   lo_idx, hi_idx, gnt_idx;
  logic [NumReq-1:0] gnt_vec;
  logic [AddrW-1:0]  gnt_addr;
  logic [Width-1:0]  gnt_wdata;

  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int j = NumReq - 1; j >= 0; j--) begin
      if (bus.req_valid_i[j]) begin
        lo_found = 1'b1;
        lo_idx   = IdxW'(j);
        if (IdxW'(j) > last_gnt_q) begin
          hi_found = 1'b1;
          hi_idx   = IdxW'(j);
        end
      end
    end
    gnt_any   = (state_q == IDLE) && !rst_i && lo_found;
    gnt_idx   = hi_found ? hi_idx : lo_idx;
    gnt_vec   = '0;
    gnt_addr  = '0;
    gnt_wdata = '0;
    for (int j = 0; j < NumReq; j++) begin
      if (IdxW'(j) == gnt_idx) begin
        gnt_vec[j] = gnt_any;
        gnt_addr   = bus.req_addr_i[j];
        gnt_wdata  = bus.req_wdata_i[j];
      end
    end
  end

  // Address decode doubles as the range check: an index >= NumCsr hits nothing.
  logic [NumCsr-1:0] addr_hit;
  logic              gnt_ok;

  always_comb begin
    addr_hit = '0;
    for (int i = 0; i < NumCsr; i++) addr_hit[i] = (gnt_addr == AddrW'(i));
    gnt_ok = |(addr_hit & ~bus.csr_lock_i);
  end

  logic [Width-1:0]  rd_sel;
  logic              err_sel;
  logic [NumReq-1:0] idx_vec;
  logic [1:0]        chk_status;

  always_comb begin
    rd_sel  = '0;
    err_sel = 1'b0;
    for (int i = 0; i < NumCsr; i++) begin
      if (addr_q == AddrW'(i)) begin
        rd_sel  = bus.csr_rd_data_i[i];
        err_sel = bus.csr_rd_error_i[i];
      end
    end
    idx_vec = '0;
    for (int j = 0; j < NumReq; j++) idx_vec[j] = (idx_q == IdxW'(j));
    if (status_q != StOk)                      chk_status = status_q;
    else if (err_sel)                          chk_status = StShadow;
    else if (|((rd_sel ^ wdata_q) & VerifyMask)) chk_status = StMismatch;
    else                                       chk_status = StOk;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_gnt_q <= IdxW'(NumReq - 1);
      addr_q     <= '0;
      wdata_q    <= '0;
      status_q   <= StOk;
      wr_en_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_any) begin
            idx_q      <= gnt_idx;
            last_gnt_q <= gnt_idx;
            addr_q     <= gnt_addr;
            wdata_q    <= gnt_wdata;
            busy_q     <= 1'b1;
            if (gnt_ok) begin
              status_q <= StOk;
              wr_en_q  <= addr_hit;
              state_q  <= WRITE;
            end else begin
              status_q <= StLocked;
              done_q   <= gnt_vec;
              state_q  <= CHECK;
            end
          end
        end
        WRITE: begin
          wr_en_q <= '0;
          state_q <= SETTLE;
        end
        SETTLE: begin
          done_q  <= idx_vec;
          state_q <= CHECK;
        end
        CHECK: begin
          done_q   <= '0;
          busy_q   <= 1'b0;
          wdata_q  <= '0;
          status_q <= StOk;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_gnt_o     = gnt_vec;
  assign bus.req_done_o    = done_q;
  assign bus.req_status_o  = (|done_q) ? chk_status : StOk;
  assign bus.csr_wr_en_o   = wr_en_q;
  assign bus.csr_wr_data_o = wdata_q;
  assign bus.busy_o        = busy_q;
endmodule

// File: tb/tb_ibex_csr_wr_sequencer.sv
// Bench for ibex_csr_wr_sequencer: a register-bank model plus a done/status scoreboard.
// Each scenario task checks its own cycle timing.
module tb_ibex_csr_wr_sequencer;
  localparam int NumReq = 3;
  localparam int NumCsr = 8;
  localparam int AddrW  = 4;
  localparam int Width  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_csr_wr_sequencer_if #(.NumReq(NumReq), .NumCsr(NumCsr), .AddrW(AddrW), .Width(Width)) bus ();

  ibex_csr_wr_sequencer #(.NumReq(NumReq), .NumCsr(NumCsr), .AddrW(AddrW), .Width(Width)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic [1:0] st;
  } exp_t;
  exp_t sb[$];

  // Bank model: stores written data; read-back can be overridden to mimic self-modification.
  logic [NumCsr-1:0][Width-1:0] mem;
  logic             ovr_en  = 1'b0;
  logic [Width-1:0] ovr_val = '0;
  int               wr_cnt[NumCsr] = '{default: 0};

  always @(posedge clk) begin
    for (int i = 0; i < NumCsr; i++) begin
      if (rst) mem[i] <= '0;
      else if (bus.csr_wr_en_o[i]) mem[i] <= bus.csr_wr_data_o;
      if (bus.csr_wr_en_o[i]) wr_cnt[i] <= wr_cnt[i] + 1;
    end
  end

  always_comb begin
    for (int i = 0; i < NumCsr; i++) bus.csr_rd_data_i[i] = ovr_en ? ovr_val : mem[i];
  end

  // Scoreboard: every done pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t             e;
    logic [NumReq-1:0] want;
    if (!rst && bus.req_done_o != '0) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL done_unexpected: got done=%b st=%0d, want no done", bus.req_done_o, bus.req_status_o);
      end else begin
        e = sb.pop_front();
        want = '0;
        want[e.idx] = 1'b1;
        if (bus.req_done_o !== want || bus.req_status_o !== e.st) begin
          bad++;
          $display("FAIL done_status: got done=%b st=%0d, want done=%b st=%0d",
                   bus.req_done_o, bus.req_status_o, want, e.st);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || bus.busy_o) && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0 || bus.busy_o) begin
      bad++;
      $display("FAIL wait_done: got pending=%0d busy=%b, want 0 and 0", sb.size(), bus.busy_o);
    end
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid_i = 3'b001;
    repeat (2) @(negedge clk);
    total++; if (bus.req_gnt_o !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b want 000", bus.req_gnt_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    total++; if (bus.csr_wr_en_o !== 8'h00) begin bad++; $display("FAIL reset_wr_en: got %b want 0", bus.csr_wr_en_o); end
    total++; if (bus.req_done_o !== 3'b000) begin bad++; $display("FAIL reset_done: got %b want 000", bus.req_done_o); end
    total++; if (bus.req_status_o !== 2'd0) begin bad++; $display("FAIL reset_status: got %0d want 0", bus.req_status_o); end
    total++; if (bus.csr_wr_data_o !== 32'h0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", bus.csr_wr_data_o); end
    cyc();
    bus.req_valid_i = '0;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single();
    bus.req_addr_i[1]  = 4'd2;
    bus.req_wdata_i[1] = 32'h0000_00A5;
    bus.req_valid_i[1] = 1'b1;
    sb.push_back('{1, 2'd0});
    @(negedge clk);
    total++; if (bus.req_gnt_o !== 3'b010) begin bad++; $display("FAIL single_gnt: got %b want 010", bus.req_gnt_o); end
    cyc();
    bus.req_valid_i[1] = 1'b0;
    @(negedge clk);
    total++; if (bus.csr_wr_en_o !== 8'b0000_0100) begin bad++; $display("FAIL single_wr_en: got %b want 00000100", bus.csr_wr_en_o); end
    total++; if (bus.csr_wr_data_o !== 32'hA5) begin bad++; $display("FAIL single_wr_data: got %h want a5", bus.csr_wr_data_o); end
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.busy_o); end
    @(negedge clk);
    total++; if (bus.csr_wr_en_o !== 8'h00) begin bad++; $display("FAIL single_settle_en: got %b want 0", bus.csr_wr_en_o); end
    @(negedge clk);
    total++; if (bus.req_done_o !== 3'b010) begin bad++; $display("FAIL single_done_time: got %b want 010", bus.req_done_o); end
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0 || bus.csr_wr_data_o !== 32'h0) begin
      bad++; $display("FAIL single_idle: got busy=%b data=%h want 0 and 0", bus.busy_o, bus.csr_wr_data_o);
    end
    cyc();
  endtask

  task automatic test_mask();
    ovr_en  = 1'b1;
    ovr_val = 32'h0000_0010;
    bus.req_addr_i[0]  = 4'd3;
    bus.req_wdata_i[0] = 32'h0000_0030;
    bus.req_valid_i[0] = 1'b1;
    sb.push_back('{0, 2'd0});
    cyc();
    bus.req_valid_i[0] = 1'b0;
    wait_done();
    ovr_val = 32'h0000_0011;
    bus.req_valid_i[0] = 1'b1;
    sb.push_back('{0, 2'd2});
    cyc();
    bus.req_valid_i[0] = 1'b0;
    wait_done();
    ovr_en = 1'b0;
  endtask

  task automatic test_lock_badaddr();
    bus.csr_lock_i[4]  = 1'b1;
    bus.req_addr_i[2]  = 4'd4;
    bus.req_wdata_i[2] = 32'h0000_00FF;
    bus.req_valid_i[2] = 1'b1;
    sb.push_back('{2, 2'd1});
    @(negedge clk);
    total++; if (bus.req_gnt_o !== 3'b100) begin bad++; $display("FAIL lock_gnt: got %b want 100", bus.req_gnt_o); end
    cyc();
    bus.req_valid_i[2] = 1'b0;
    @(negedge clk);
    total++; if (bus.csr_wr_en_o !== 8'h00 || bus.req_done_o !== 3'b100) begin
      bad++; $display("FAIL lock_t1: got en=%b done=%b want 0 and 100", bus.csr_wr_en_o, bus.req_done_o);
    end
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL lock_busy: got %b want 0", bus.busy_o); end
    total++; if (wr_cnt[4] !== 0) begin bad++; $display("FAIL lock_no_write: got %0d writes want 0", wr_cnt[4]); end
    cyc();
    bus.csr_lock_i[4] = 1'b0;

    bus.req_addr_i[0]  = 4'd9;
    bus.req_wdata_i[0] = 32'h1;
    bus.req_valid_i[0] = 1'b1;
    sb.push_back('{0, 2'd1});
    cyc();
    bus.req_valid_i[0] = 1'b0;
    @(negedge clk);
    total++; if (bus.csr_wr_en_o !== 8'h00 || bus.req_done_o !== 3'b001) begin
      bad++; $display("FAIL badaddr_t1: got en=%b done=%b want 0 and 001", bus.csr_wr_en_o, bus.req_done_o);
    end
    cyc();

    // A lock raised after the grant must not cancel the accepted write.
    bus.req_addr_i[1]  = 4'd5;
    bus.req_wdata_i[1] = 32'h0000_5A5A;
    bus.req_valid_i[1] = 1'b1;
    sb.push_back('{1, 2'd0});
    cyc();
    bus.req_valid_i[1] = 1'b0;
    bus.csr_lock_i[5]  = 1'b1;
    @(negedge clk);
    total++; if (bus.csr_wr_en_o !== 8'b0010_0000) begin bad++; $display("FAIL late_lock_en: got %b want 00100000", bus.csr_wr_en_o); end
    wait_done();
    bus.csr_lock_i[5] = 1'b0;
  endtask

  task automatic test_shadow();
    ovr_en  = 1'b1;
    ovr_val = 32'h0000_5678;
    bus.csr_rd_error_i[6] = 1'b1;
    bus.req_addr_i[1]  = 4'd6;
    bus.req_wdata_i[1] = 32'h0000_1234;
    bus.req_valid_i[1] = 1'b1;
    sb.push_back('{1, 2'd3});
    cyc();
    bus.req_valid_i[1] = 1'b0;
    wait_done();
    // Error on a neighbouring CSR must not leak into this check.
    ovr_en = 1'b0;
    bus.csr_rd_error_i = 8'b0010_0000;
    bus.req_wdata_i[1] = 32'h0000_CAFE;
    bus.req_valid_i[1] = 1'b1;
    sb.push_back('{1, 2'd0});
    cyc();
    bus.req_valid_i[1] = 1'b0;
    wait_done();
    bus.csr_rd_error_i = '0;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int last_c = 0;
    int cnt[NumReq] = '{default: 0};
    logic [NumReq-1:0] want;
    rst = 1'b1;
    cyc();
    cyc();
    bus.req_addr_i  = {4'd7, 4'd1, 4'd0};
    bus.req_wdata_i = {32'h107, 32'h101, 32'h100};
    for (int k = 0; k < 12; k++) sb.push_back('{k % NumReq, 2'd0});
    bus.req_valid_i = 3'b111;
    rst = 1'b0;
    for (int c = 0; c < 80 && n < 12; c++) begin
      @(negedge clk);
      if (bus.req_gnt_o != '0) begin
        want = '0;
        want[n % NumReq] = 1'b1;
        total++; if (bus.req_gnt_o !== want) begin bad++; $display("FAIL rr_order: grant %0d got %b want %b", n, bus.req_gnt_o, want); end
        if (n > 0) begin
          total++; if (c - last_c != 4) begin bad++; $display("FAIL rr_spacing: grant %0d got gap %0d want 4", n, c - last_c); end
        end
        for (int j = 0; j < NumReq; j++) if (bus.req_gnt_o[j]) cnt[j]++;
        last_c = c;
        n++;
      end
    end
    cyc();
    bus.req_valid_i = '0;
    total++; if (n != 12) begin bad++; $display("FAIL rr_timeout: got %0d grants want 12", n); end
    for (int j = 0; j < NumReq; j++) begin
      total++; if (cnt[j] != 4) begin bad++; $display("FAIL rr_count: requester %0d got %0d want 4", j, cnt[j]); end
    end
    wait_done();
  endtask

  task automatic test_reset_mid();
    int w0;
    w0 = wr_cnt[2];
    bus.req_addr_i  = {4'd0, 4'd2, 4'd0};
    bus.req_wdata_i = {32'h0, 32'h77, 32'h55};
    bus.req_valid_i = 3'b010;
    @(negedge clk);
    total++; if (bus.req_gnt_o !== 3'b010) begin bad++; $display("FAIL mid_gnt: got %b want 010", bus.req_gnt_o); end
    cyc();
    bus.req_valid_i = 3'b011;
    @(negedge clk);
    total++; if (bus.csr_wr_en_o !== 8'b0000_0100) begin bad++; $display("FAIL mid_wr_en: got %b want 00000100", bus.csr_wr_en_o); end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.busy_o !== 1'b0 || bus.csr_wr_en_o !== 8'h00 || bus.req_done_o !== 3'b000 ||
                 bus.req_status_o !== 2'd0 || bus.csr_wr_data_o !== 32'h0 || bus.req_gnt_o !== 3'b000) begin
      bad++; $display("FAIL mid_reset_outs: got busy=%b en=%b done=%b st=%0d data=%h gnt=%b want all 0",
                      bus.busy_o, bus.csr_wr_en_o, bus.req_done_o, bus.req_status_o, bus.csr_wr_data_o, bus.req_gnt_o);
    end
    cyc();
    rst = 1'b0;
    sb.push_back('{0, 2'd0});
    @(negedge clk);
    total++; if (bus.req_gnt_o !== 3'b001) begin bad++; $display("FAIL mid_fresh_gnt: got %b want 001", bus.req_gnt_o); end
    cyc();
    bus.req_valid_i = '0;
    wait_done();
    total++; if (wr_cnt[2] - w0 != 1) begin bad++; $display("FAIL mid_single_write: got %0d writes want 1", wr_cnt[2] - w0); end
  endtask

  initial begin
    bus.req_valid_i    = '0;
    bus.req_addr_i     = '0;
    bus.req_wdata_i    = '0;
    bus.csr_lock_i     = '0;
    bus.csr_rd_error_i = '0;
    test_reset();
    test_single();
    test_mask();
    test_lock_badaddr();
    test_shadow();
    test_back_to_back();
    test_reset_mid();
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
